layer1_accumulator: RTL and testbench

LAYER1_ACCUMULATOR -- requirements
Module: layer1_accumulator

---
 rtl/layer1_accumulator.sv | 138 +++++++++++++
 tb/tb_layer1_accumulator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer1_accumulator.sv
// Layer-1 conv accumulator: sums TAPS partial-sum beats plus bias per lane, saturates to Q5.10.
// Optional build macro LAYER1_RELU_EN clamps negative results to zero after saturation.
module layer1_accumulator #(
  parameter int TAPS = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] bias,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   tap_cnt
);

  localparam int LANES = 8;
  localparam logic [3:0] LAST_TAP = 4'(TAPS - 1);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          tap_q, tap_d;
  logic signed [19:0]  acc_q [LANES];
  logic signed [19:0]  acc_d [LANES];
  logic                out_valid_q, out_valid_d;
  logic [127:0]        out_data_q, out_data_d;

  logic signed [19:0]  beat_ext [LANES];
  logic signed [19:0]  bias_ext [LANES];
  logic signed [19:0]  final_sum [LANES];
  logic [15:0]         lane_result [LANES];

  logic accept;
  logic final_tap;

  function automatic logic [15:0] sat16(input logic signed [19:0] v);
    if (v > 20'sd32767) begin
      return 16'h7FFF;
    end else if (v < -20'sd32768) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

  function automatic logic [15:0] post_sat(input logic [15:0] r);
`ifdef LAYER1_RELU_EN
    return r[15] ? 16'h0000 : r;
`else
    return r;
`endif
  endfunction

  // Only a finished pixel waiting on a stalled consumer can block the last tap.
  assign in_ready  = !((tap_q == LAST_TAP) && out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready;
  assign final_tap = accept && (tap_q == LAST_TAP);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign tap_cnt   = tap_q;

  // Lane 0 is channel1, which lives in the top 16 bits of the bus.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      beat_ext[i]    = 20'(signed'(in_data[16*(LANES-1-i) +: 16]));
      bias_ext[i]    = 20'(signed'(bias[16*(LANES-1-i) +: 16]));
      final_sum[i]   = acc_q[i] + beat_ext[i];
      lane_result[i] = post_sat(sat16(final_sum[i]));
    end
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    for (int i = 0; i < LANES; i++) begin
      acc_d[i] = acc_q[i];
    end

    if (accept) begin
      if (final_tap) begin
        state_d = IDLE;
        tap_d   = 4'd0;
      end else begin
        state_d = ACCUM;
        tap_d   = tap_q + 4'd1;
      end
    end

    for (int i = 0; i < LANES; i++) begin
      if (final_tap) begin
        acc_d[i] = 20'sd0;
      end else if (accept && (state_q == IDLE)) begin
        acc_d[i] = bias_ext[i] + beat_ext[i];
      end else if (accept) begin
        acc_d[i] = acc_q[i] + beat_ext[i];
      end
    end

    // A new result replaces the old one even when it is consumed this cycle.
    if (final_tap) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < LANES; i++) begin
        out_data_d[16*(LANES-1-i) +: 16] = lane_result[i];
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 128'd0;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= 20'sd0;
      end
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_layer1_accumulator.sv
// Self-checking bench for layer1_accumulator: vector table, corner sequences and random traffic
// compared against a per-lane integer-sum reference model.
module tb_layer1_accumulator;

  localparam int TAPS = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] bias = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [3:0]   tap_cnt;

  logic         d4_in_valid = 1'b0;
  logic         d4_in_ready;
  logic [127:0] d4_in_data = '0;
  logic [127:0] d4_bias = '0;
  logic         d4_out_valid;
  logic         d4_out_ready = 1'b1;
  logic [127:0] d4_out_data;
  logic [3:0]   d4_tap_cnt;

  int total = 0;
  int bad = 0;

  int           m_sum [8];
  int           m_taps;
  logic         m_valid;
  logic [127:0] m_data;

  typedef struct {
    logic [127:0] bias_v;
    logic [127:0] tap_v;
    logic [127:0] exp_sat;
    logic [127:0] exp_relu;
  } vec_t;

  layer1_accumulator #(.TAPS(TAPS)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bias(bias), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .tap_cnt(tap_cnt)
  );

  layer1_accumulator #(.TAPS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .in_data(d4_in_data), .bias(d4_bias), .out_valid(d4_out_valid),
    .out_ready(d4_out_ready), .out_data(d4_out_data), .tap_cnt(d4_tap_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int lane_of(input logic [127:0] v, input int i);
    logic signed [15:0] s;
    s = v[16*(7-i) +: 16];
    return int'(s);
  endfunction

  function automatic logic [15:0] ref_result(input int v);
    int r;
    r = (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
`ifdef LAYER1_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[15:0];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand_lanes(input int mag);
    logic [127:0] v;
    int x;
    for (int i = 0; i < 8; i++) begin
      x = int'($urandom_range(0, 2 * mag)) - mag;
      v[16*(7-i) +: 16] = x[15:0];
    end
    return v;
  endfunction

  task automatic checkOutput();
    check("tap_cnt", {124'd0, tap_cnt}, 128'(m_taps));
    check("out_valid", {127'd0, out_valid}, {127'd0, m_valid});
    check("out_data", out_data, m_data);
  endtask

  task automatic applyStimulus(input logic v, input logic [127:0] d, input logic [127:0] b,
                               input logic ordy);
    bit m_ready;
    bit accepted;
    in_valid  = v;
    in_data   = d;
    bias      = b;
    out_ready = ordy;
    #1;
    m_ready = !((m_taps == TAPS - 1) && m_valid && !ordy);
    check("in_ready", {127'd0, in_ready}, {127'd0, m_ready});
    accepted = v && m_ready;
    @(posedge clk);
    if (accepted) begin
      for (int i = 0; i < 8; i++) begin
        if (m_taps == 0) m_sum[i] = lane_of(b, i) + lane_of(d, i);
        else m_sum[i] = m_sum[i] + lane_of(d, i);
      end
      m_taps++;
    end
    if (accepted && m_taps == TAPS) begin
      for (int i = 0; i < 8; i++) m_data[16*(7-i) +: 16] = ref_result(m_sum[i]);
      m_valid = 1'b1;
      m_taps  = 0;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    m_taps  = 0;
    m_valid = 1'b0;
    m_data  = '0;
    for (int i = 0; i < 8; i++) m_sum[i] = 0;
    checkOutput();
    rst = 1'b0;
  endtask

  initial begin
    vec_t vecs [4];
    logic [127:0] exp_v;

    vecs[0] = '{{8{16'h0000}}, {8{16'h0400}}, {8{16'h2400}}, {8{16'h2400}}};
    vecs[1] = '{{16'hFC00, {7{16'h0000}}},
                {16'h0400, 16'h7000, 16'h9000, 16'h0001, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF},
                {16'h2000, 16'h7FFF, 16'h8000, 16'h0009, 16'hFFF7, 16'h0000, 16'h8000, 16'h7FFF},
                {16'h2000, 16'h7FFF, 16'h0000, 16'h0009, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF}};
    vecs[2] = '{{8{16'h0100}}, {8{16'hFF00}}, {8{16'hF800}}, {8{16'h0000}}};
    vecs[3] = '{{{4{16'h7FFF}}, {4{16'h8000}}}, {{4{16'h7FFF}}, {4{16'h8000}}},
                {{4{16'h7FFF}}, {4{16'h8000}}}, {{4{16'h7FFF}}, {4{16'h0000}}}};

    doReset();

    for (int t = 0; t < 4; t++) begin
      d4_in_valid = 1'b1;
      d4_in_data  = {8{16'h0400}};
      #1;
      check("d4_tap_seq", {124'd0, d4_tap_cnt}, 128'(t));
      check("d4_in_ready", {127'd0, d4_in_ready}, 128'd1);
      @(posedge clk);
      #1;
    end
    d4_in_valid = 1'b0;
    check("d4_tap_wrap", {124'd0, d4_tap_cnt}, 128'd0);
    check("d4_valid", {127'd0, d4_out_valid}, 128'd1);
    check("d4_data", d4_out_data, {8{16'h1000}});

    for (int k = 0; k < 4; k++) begin
`ifdef LAYER1_RELU_EN
      exp_v = vecs[k].exp_relu;
`else
      exp_v = vecs[k].exp_sat;
`endif
      for (int t = 0; t < TAPS; t++) begin
        applyStimulus(1'b1, vecs[k].tap_v, (t == 0) ? vecs[k].bias_v : rand128(), 1'b1);
      end
      check("tbl_valid", {127'd0, out_valid}, 128'd1);
      check("tbl_data", out_data, exp_v);
      check("tbl_tap_cnt", {124'd0, tap_cnt}, 128'd0);
      applyStimulus(1'b0, rand128(), rand128(), 1'b1);
      check("tbl_drain", {127'd0, out_valid}, 128'd0);
    end

    for (int t = 0; t < 17; t++) begin
      applyStimulus(1'b1, (t < TAPS) ? {8{16'h0100}} : {8{16'h0200}}, '0, 1'b0);
    end
    for (int s = 0; s < 2; s++) begin
      in_valid  = 1'b1;
      in_data   = {8{16'h0200}};
      out_ready = 1'b0;
      #1;
      check("bp_stall_ready", {127'd0, in_ready}, 128'd0);
      applyStimulus(1'b1, {8{16'h0200}}, rand128(), 1'b0);
      check("bp_hold", out_data, {8{16'h0900}});
    end
    applyStimulus(1'b1, {8{16'h0200}}, rand128(), 1'b1);
    check("bp_no_bubble", {127'd0, out_valid}, 128'd1);
    check("bp_second", out_data, {8{16'h1200}});
    applyStimulus(1'b0, rand128(), rand128(), 1'b1);

    for (int t = 0; t < 5; t++) applyStimulus(1'b1, {8{16'h0400}}, '0, 1'b1);
    doReset();
    check("rst_valid", {127'd0, out_valid}, 128'd0);
    for (int t = 0; t < TAPS; t++) applyStimulus(1'b1, {8{16'h0400}}, '0, 1'b1);
    check("rst_result", out_data, {8{16'h2400}});
    applyStimulus(1'b0, rand128(), rand128(), 1'b1);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0,
                      ($urandom_range(0, 1) != 0) ? rand_lanes(600) : rand128(),
                      ($urandom_range(0, 1) != 0) ? rand_lanes(4000) : rand128(),
                      $urandom_range(0, 2) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
